// File: rtl/dpram_pkg.sv
// Shared definitions for the pipelined dual-port RAM: latency limits, clear-sequencer
// states and the collision policy that both the RAM and its scoreboard rely on.
package dpram_pkg;

    localparam int READ_LATENCY_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN
    } dpram_state_t;

    typedef enum logic {
        PORT_A,
        PORT_B
    } dpram_port_t;

    // Same-address dual write keeps the winner's data; cross-port reads see pre-write contents.
    localparam dpram_port_t WRITE_COLLISION_WINNER = PORT_A;
    localparam bit          CROSS_READ_FIRST       = 1'b1;

    function automatic bit latency_legal(input int latency);
        return (latency >= 1) && (latency <= READ_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-return delay line for one RAM port: carries {valid,data} from the array read
// register to the port outputs, holding the last returned word while idle.
module dpram_rd_pipe
    import dpram_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  pipe_valid,
    output logic [DATA_WIDTH-1:0] pipe_data
);

    // The array read register already provides one cycle of the latency.
    localparam int STAGES = READ_LATENCY - 1;

    if (STAGES == 0) begin : g_direct
        assign pipe_valid = rd_valid;
        assign pipe_data  = rd_data;
    end else begin : g_stages
        logic [STAGES-1:0]     valid_q;
        logic [DATA_WIDTH-1:0] data_q [STAGES];

        // Data only advances alongside a valid token, so the last stage holds between reads.
        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= '0;
                for (int i = 0; i < STAGES; i++) begin
                    data_q[i] <= '0;
                end
            end else begin
                valid_q[0] <= rd_valid;
                if (rd_valid) begin
                    data_q[0] <= rd_data;
                end
                for (int i = 1; i < STAGES; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign pipe_valid = valid_q[STAGES-1];
        assign pipe_data  = data_q[STAGES-1];
    end

endmodule

// File: rtl/dpram_pipelined.sv
// Single-clock true dual-port RAM with registered read pipeline and per-port valid.
// Define DPRAM_INIT_CLEAR_EN to zero the whole array after every reset before accepting requests.
module dpram_pipelined
    import dpram_pkg::*;
#(
    parameter int    DATA_WIDTH   = 8,
    parameter int    ADDR_WIDTH   = 10,
    parameter int    READ_LATENCY = 2,
    parameter string INIT_FILE    = ""
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    output logic                  ready_out,
    input  logic [ADDR_WIDTH-1:0] addra_in,
    input  logic [DATA_WIDTH-1:0] dina_in,
    input  logic                  ena_in,
    input  logic                  wea_in,
    output logic [DATA_WIDTH-1:0] douta_out,
    output logic                  douta_valid,
    input  logic [ADDR_WIDTH-1:0] addrb_in,
    input  logic [DATA_WIDTH-1:0] dinb_in,
    input  logic                  enb_in,
    input  logic                  web_in,
    output logic [DATA_WIDTH-1:0] doutb_out,
    output logic                  doutb_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("dpram_pipelined: READ_LATENCY must be between 1 and %0d", READ_LATENCY_MAX);
    end

    logic                  ready;
    logic                  clear_we;
    logic [ADDR_WIDTH-1:0] clear_addr;

`ifdef DPRAM_INIT_CLEAR_EN
    dpram_state_t          state_q;
    dpram_state_t          state_next;
    logic [ADDR_WIDTH-1:0] clear_addr_q;
    logic [ADDR_WIDTH-1:0] clear_addr_next;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_IDLE;
            clear_addr_q <= '0;
        end else begin
            state_q      <= state_next;
            clear_addr_q <= clear_addr_next;
        end
    end

    always_comb begin
        state_next      = state_q;
        clear_addr_next = clear_addr_q;
        case (state_q)
            ST_IDLE: begin
                state_next      = ST_CLEAR;
                clear_addr_next = '0;
            end
            ST_CLEAR: begin
                if (clear_addr_q == '1) begin
                    state_next = ST_RUN;
                end else begin
                    clear_addr_next = clear_addr_q + 1'b1;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_IDLE;
        endcase
    end

    // The clear borrows port A's write path; both ports stay closed until it finishes.
    always_comb begin
        ready      = (state_q == ST_RUN);
        clear_we   = (state_q == ST_CLEAR) & ~rst_in;
        clear_addr = clear_addr_q;
    end
`else
    logic ready_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    assign ready      = ready_q;
    assign clear_we   = 1'b0;
    assign clear_addr = '0;
`endif

    assign ready_out = ready;

    logic                  acc_a;
    logic                  acc_b;
    logic                  rd_a;
    logic                  rd_b;
    logic                  req_wr_a;
    logic                  req_wr_b;
    logic                  collide;
    logic                  wr_a;
    logic                  wr_b;
    logic [ADDR_WIDTH-1:0] wr_a_addr;
    logic [DATA_WIDTH-1:0] wr_a_data;

    always_comb begin
        acc_a     = ena_in & ready & ~rst_in;
        acc_b     = enb_in & ready & ~rst_in;
        rd_a      = acc_a & ~wea_in;
        rd_b      = acc_b & ~web_in;
        req_wr_a  = clear_we | (acc_a & wea_in);
        req_wr_b  = acc_b & web_in;
        wr_a_addr = clear_we ? clear_addr : addra_in;
        wr_a_data = clear_we ? '0 : dina_in;
        collide   = req_wr_a & req_wr_b & (wr_a_addr == addrb_in);
        wr_a      = req_wr_a & ~(collide & (WRITE_COLLISION_WINNER == PORT_B));
        wr_b      = req_wr_b & ~(collide & (WRITE_COLLISION_WINNER == PORT_A));
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_in) begin
        if (wr_a) begin
            mem[wr_a_addr] <= wr_a_data;
        end
        if (wr_b) begin
            mem[addrb_in] <= dinb_in;
        end
    end

    // Reads sit in separate processes from the writes, giving read-first on cross-port hits.
    logic                  rvalid_a;
    logic                  rvalid_b;
    logic [DATA_WIDTH-1:0] rdata_a;
    logic [DATA_WIDTH-1:0] rdata_b;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rvalid_a <= 1'b0;
            rdata_a  <= '0;
        end else begin
            rvalid_a <= rd_a;
            if (rd_a) begin
                rdata_a <= mem[addra_in];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rvalid_b <= 1'b0;
            rdata_b  <= '0;
        end else begin
            rvalid_b <= rd_b;
            if (rd_b) begin
                rdata_b <= mem[addrb_in];
            end
        end
    end

    dpram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe_a (
        .clk        (clk_in),
        .rst        (rst_in),
        .rd_valid   (rvalid_a),
        .rd_data    (rdata_a),
        .pipe_valid (douta_valid),
        .pipe_data  (douta_out)
    );

    dpram_rd_pipe #(
        .DATA_WIDTH   (DATA_WIDTH),
        .READ_LATENCY (READ_LATENCY)
    ) u_pipe_b (
        .clk        (clk_in),
        .rst        (rst_in),
        .rd_valid   (rvalid_b),
        .rd_data    (rdata_b),
        .pipe_valid (doutb_valid),
        .pipe_data  (doutb_out)
    );

endmodule

// File: tb/tb_dpram_pipelined.sv
// Self-checking bench for dpram_pipelined: directed vector table, hand-written corner
// sequences and a randomized run against a timestamp-based reference model.
module tb_dpram_pipelined;
    import dpram_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;
`ifdef DPRAM_INIT_CLEAR_EN
    localparam int READY_GAP = DEPTH + 1;
`else
    localparam int READY_GAP = 1;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          ready_out;
    logic [AW-1:0] addra_in = '0;
    logic [DW-1:0] dina_in = '0;
    logic          ena_in = 1'b0;
    logic          wea_in = 1'b0;
    logic [DW-1:0] douta_out;
    logic          douta_valid;
    logic [AW-1:0] addrb_in = '0;
    logic [DW-1:0] dinb_in = '0;
    logic          enb_in = 1'b0;
    logic          web_in = 1'b0;
    logic [DW-1:0] doutb_out;
    logic          doutb_valid;

    always #5 clk_in = ~clk_in;

    dpram_pipelined #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .READ_LATENCY (LAT),
        .INIT_FILE    ("")
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ready_out   (ready_out),
        .addra_in    (addra_in),
        .dina_in     (dina_in),
        .ena_in      (ena_in),
        .wea_in      (wea_in),
        .douta_out   (douta_out),
        .douta_valid (douta_valid),
        .addrb_in    (addrb_in),
        .dinb_in     (dinb_in),
        .enb_in      (enb_in),
        .web_in      (web_in),
        .doutb_out   (doutb_out),
        .doutb_valid (doutb_valid)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: reads are stamped with the edge that accepted them and reappear LAT-1 edges later.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_known [DEPTH];
    bit            m_iss_a [int];
    bit            m_iss_b [int];
    logic [DW-1:0] m_iss_da [int];
    logic [DW-1:0] m_iss_db [int];
    bit            m_iss_ka [int];
    bit            m_iss_kb [int];
    int            edge_n   = 0;
    int            last_rst = -100000;
    bit            m_ready  = 1'b0;
    bit            m_va = 1'b0, m_vb = 1'b0, m_ka = 1'b0, m_kb = 1'b0;
    logic [DW-1:0] m_da = '0, m_db = '0;

    task automatic model_edge();
        bit acc_a, acc_b, wa, wb, same;
        int src;
        edge_n++;
        acc_a = ena_in && m_ready && !rst_in;
        acc_b = enb_in && m_ready && !rst_in;
        if (rst_in) begin
            last_rst = edge_n;
            m_va = 0; m_vb = 0; m_da = '0; m_db = '0; m_ka = 1; m_kb = 1;
            m_ready = 0;
        end else begin
            if (acc_a && !wea_in) begin
                m_iss_a[edge_n] = 1; m_iss_da[edge_n] = m_mem[addra_in]; m_iss_ka[edge_n] = m_known[addra_in];
            end
            if (acc_b && !web_in) begin
                m_iss_b[edge_n] = 1; m_iss_db[edge_n] = m_mem[addrb_in]; m_iss_kb[edge_n] = m_known[addrb_in];
            end
            wa   = acc_a && wea_in;
            wb   = acc_b && web_in;
            same = (addra_in == addrb_in);
            if (wb && !(wa && same && WRITE_COLLISION_WINNER == PORT_A)) begin
                m_mem[addrb_in] = dinb_in; m_known[addrb_in] = 1;
            end
            if (wa && !(wb && same && WRITE_COLLISION_WINNER == PORT_B)) begin
                m_mem[addra_in] = dina_in; m_known[addra_in] = 1;
            end
            src = edge_n - (LAT - 1);
            if (src > last_rst && m_iss_a.exists(src)) begin
                m_va = 1; m_da = m_iss_da[src]; m_ka = m_iss_ka[src];
            end else begin
                m_va = 0;
            end
            if (src > last_rst && m_iss_b.exists(src)) begin
                m_vb = 1; m_db = m_iss_db[src]; m_kb = m_iss_kb[src];
            end else begin
                m_vb = 0;
            end
            if (!m_ready && (edge_n - last_rst) >= READY_GAP) begin
                m_ready = 1;
`ifdef DPRAM_INIT_CLEAR_EN
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i] = '0; m_known[i] = 1;
                end
`endif
            end
        end
    endtask

    task automatic apply_stimulus(input bit rst, input bit ea, input bit wa, input logic [AW-1:0] aa,
                                  input logic [DW-1:0] da, input bit eb, input bit wb,
                                  input logic [AW-1:0] ab, input logic [DW-1:0] db);
        rst_in = rst; ena_in = ea; wea_in = wa; addra_in = aa; dina_in = da;
        enb_in = eb; web_in = wb; addrb_in = ab; dinb_in = db;
        @(posedge clk_in);
        model_edge();
        @(negedge clk_in);
    endtask

    task automatic idle(input bit rst);
        apply_stimulus(rst, 0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check_output("ready_model", ready_out, m_ready);
        check_output("va_model", douta_valid, m_va);
        check_output("vb_model", doutb_valid, m_vb);
        if (m_ka) check_output("da_model", douta_out, m_da);
        if (m_kb) check_output("db_model", doutb_out, m_db);
    endtask

    task automatic wait_ready();
        bit got = 0;
        for (int i = 0; i < READY_GAP + 8 && !got; i++) begin
            idle(0);
            check_model();
            if (ready_out === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL ready_timeout: actual=0 required=1");
        end
    endtask

    function automatic logic [DW-1:0] pat_a(input int i);
        return DW'(i * 13 + 5);
    endfunction

    function automatic logic [DW-1:0] pat_b(input int i);
        return DW'(255 - i * 7);
    endfunction

    typedef struct {
        bit            ena, wea;
        logic [AW-1:0] addra;
        logic [DW-1:0] dina;
        bit            enb, web;
        logic [AW-1:0] addrb;
        logic [DW-1:0] dinb;
        bit            va;
        logic [DW-1:0] da;
        bit            vb;
        logic [DW-1:0] db;
    } vec_t;

    vec_t tbl [16];

    initial begin
        int cnt_a, cnt_b;
        bit ev;

        // Directed table: expected outputs are those visible in the cycle after each request.
        tbl[0]  = '{1, 1, 10'h010, 8'h5A, 0, 0, 10'h000, 8'h00, 0, 8'h00, 0, 8'h00};
        tbl[1]  = '{1, 0, 10'h010, 8'h00, 0, 0, 10'h000, 8'h00, 0, 8'h00, 0, 8'h00};
        tbl[2]  = '{0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 1, 8'h5A, 0, 8'h00};
        tbl[3]  = '{0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 8'h5A, 0, 8'h00};
        tbl[4]  = '{1, 1, 10'h3FF, 8'h11, 1, 1, 10'h3FF, 8'h22, 0, 8'h5A, 0, 8'h00};
        tbl[5]  = '{1, 0, 10'h3FF, 8'h00, 1, 0, 10'h3FF, 8'h00, 0, 8'h5A, 0, 8'h00};
        tbl[6]  = '{0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 1, 8'h11, 1, 8'h11};
        tbl[7]  = '{1, 1, 10'h020, 8'hAA, 0, 0, 10'h000, 8'h00, 0, 8'h11, 0, 8'h11};
        tbl[8]  = '{1, 1, 10'h020, 8'h55, 1, 0, 10'h020, 8'h00, 0, 8'h11, 0, 8'h11};
        tbl[9]  = '{0, 0, 10'h000, 8'h00, 1, 0, 10'h020, 8'h00, 0, 8'h11, 1, 8'hAA};
        tbl[10] = '{0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 8'h11, 1, 8'h55};
        tbl[11] = '{0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 8'h11, 0, 8'h55};
        tbl[12] = '{1, 1, 10'h100, 8'h33, 1, 1, 10'h101, 8'h44, 0, 8'h11, 0, 8'h55};
        tbl[13] = '{1, 0, 10'h101, 8'h00, 1, 0, 10'h100, 8'h00, 0, 8'h11, 0, 8'h55};
        tbl[14] = '{0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 1, 8'h44, 1, 8'h33};
        tbl[15] = '{0, 0, 10'h000, 8'h00, 0, 0, 10'h000, 8'h00, 0, 8'h44, 0, 8'h33};

        @(negedge clk_in);
        for (int i = 0; i < 3; i++) idle(1);
        check_output("rst_ready", ready_out, 0);
        check_output("rst_va", douta_valid, 0);
        check_output("rst_vb", doutb_valid, 0);
        check_output("rst_da", douta_out, 0);
        check_output("rst_db", doutb_out, 0);
        wait_ready();

        $display("[TB] directed table");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(0, tbl[i].ena, tbl[i].wea, tbl[i].addra, tbl[i].dina,
                           tbl[i].enb, tbl[i].web, tbl[i].addrb, tbl[i].dinb);
            check_output($sformatf("tbl%0d_va", i), douta_valid, tbl[i].va);
            check_output($sformatf("tbl%0d_da", i), douta_out, tbl[i].da);
            check_output($sformatf("tbl%0d_vb", i), doutb_valid, tbl[i].vb);
            check_output($sformatf("tbl%0d_db", i), doutb_out, tbl[i].db);
        end

        $display("[TB] burst reads");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(0, 1, 1, AW'(10'h200 + i), pat_a(i), 1, 1, AW'(10'h280 + i), pat_b(i));
        end
        cnt_a = 0;
        cnt_b = 0;
        for (int k = 0; k < 18; k++) begin
            if (k < 16) apply_stimulus(0, 1, 0, AW'(10'h200 + k), '0, 1, 0, AW'(10'h280 + k), '0);
            else        idle(0);
            ev = (k >= LAT - 1) && (k < 16 + LAT - 1);
            check_output($sformatf("burst%0d_va", k), douta_valid, ev);
            check_output($sformatf("burst%0d_vb", k), doutb_valid, ev);
            if (ev) begin
                check_output($sformatf("burst%0d_da", k), douta_out, pat_a(k - (LAT - 1)));
                check_output($sformatf("burst%0d_db", k), doutb_out, pat_b(k - (LAT - 1)));
            end
            if (douta_valid === 1'b1) cnt_a++;
            if (doutb_valid === 1'b1) cnt_b++;
        end
        check_output("burst_count_a", cnt_a, 16);
        check_output("burst_count_b", cnt_b, 16);

`ifdef DPRAM_INIT_CLEAR_EN
        $display("[TB] cleared contents");
        for (int k = 0; k < 10; k++) begin
            if (k < 8) apply_stimulus(0, 1, 0, AW'(10'h3C0 + k), '0, 1, 0, AW'(10'h3C8 + k), '0);
            else       idle(0);
            check_model();
            if (k >= LAT - 1) begin
                check_output($sformatf("clear%0d_da", k), douta_out, 0);
                check_output($sformatf("clear%0d_db", k), doutb_out, 0);
            end
        end
`endif

        $display("[TB] reset during reads");
        apply_stimulus(0, 1, 0, 10'h010, '0, 1, 0, 10'h3FF, '0);
        check_model();
        apply_stimulus(1, 1, 0, 10'h010, '0, 0, 0, '0, '0);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) idle(k < 2);
            check_output($sformatf("rstrd%0d_va", k), douta_valid, 0);
            check_output($sformatf("rstrd%0d_vb", k), doutb_valid, 0);
            check_output($sformatf("rstrd%0d_da", k), douta_out, 0);
            check_output($sformatf("rstrd%0d_db", k), doutb_out, 0);
            if (k < 2) check_output($sformatf("rstrd%0d_ready", k), ready_out, 0);
            check_model();
        end
        wait_ready();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(0, 1, 1, AW'(10'h040 + 2 * i), DW'($urandom), 1, 1, AW'(10'h041 + 2 * i), DW'($urandom));
            check_model();
        end
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 99) == 0,
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           AW'(10'h040 + $urandom_range(0, 31)), DW'($urandom),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           AW'(10'h040 + $urandom_range(0, 31)), DW'($urandom));
            check_model();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

endmodule
